// File: rtl/ibex_tl_data_adapter.sv
// ---------------------------------------------------------------------------
// ibex_tl_data_adapter
//
// Bridges the Ibex data memory interface (req/gnt/rvalid) onto a TileLink-UL
// client port. Up to N = 2**SOURCE_W requests may be in flight, each tagged
// with a distinct a_source. D responses may arrive in any order; they are
// parked in a circular slot buffer and handed back to the core in issue order.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   data_*                  Ibex core data interface (req/gnt/rvalid)
//   a_*                     TileLink A channel (Get / PutFullData / PutPartialData)
//   d_*                     TileLink D channel (AccessAck / AccessAckData)
//   outstanding_o           number of slots currently in use
//   protocol_err_o          sticky flag for unexpected or mismatched D beats
// ---------------------------------------------------------------------------
module ibex_tl_data_adapter #(
    parameter int unsigned SOURCE_W = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [31:0]         data_wdata_i,
    output logic [31:0]         data_rdata_o,
    output logic                data_err_o,

    output logic                a_valid_o,
    input  logic                a_ready_i,
    output logic [2:0]          a_opcode_o,
    output logic [2:0]          a_param_o,
    output logic [1:0]          a_size_o,
    output logic [SOURCE_W-1:0] a_source_o,
    output logic [ADDR_W-1:0]   a_address_o,
    output logic [3:0]          a_mask_o,
    output logic [31:0]         a_data_o,

    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [2:0]          d_opcode_i,
    input  logic [SOURCE_W-1:0] d_source_i,
    input  logic [31:0]         d_data_i,
    input  logic                d_denied_i,
    input  logic                d_corrupt_i,

    output logic [SOURCE_W:0]   outstanding_o,
    output logic                protocol_err_o
);

    localparam int unsigned       N   = 1 << SOURCE_W;
    localparam logic [SOURCE_W:0] CAP = (SOURCE_W + 1)'(N);

    localparam logic [2:0] OP_GET           = 3'd4;
    localparam logic [2:0] OP_PUT_FULL      = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] OP_ACCESS_ACK    = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_D  = 3'd1;

    // Slot buffer and pointers
    logic [SOURCE_W-1:0] head_q, head_d;
    logic [SOURCE_W-1:0] tail_q, tail_d;
    logic [SOURCE_W:0]   count_q, count_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [N-1:0]        done_q, done_d;
    logic [N-1:0]        we_q, we_d;
    logic [N-1:0]        err_q, err_d;
    logic [31:0]         rdata_q [N];
    logic [31:0]         rdata_d [N];
    logic                perr_q, perr_d;
    logic                drdy_q;

    logic                grant;
    logic                release_head;
    logic                d_fire;
    logic                slot_ok;
    logic                op_ok;
    logic                d_accept;
    logic                d_bad;
    logic [ADDR_W-1:0]   addr_ext;
    logic [1:0]          unused_addr_lsb;

    assign unused_addr_lsb = data_addr_i[1:0];

    // ------------------------------------------------------------------
    // Issue path
    // ------------------------------------------------------------------
    assign a_valid_o  = data_req_i && (count_q < CAP);
    assign grant      = a_valid_o && a_ready_i;
    assign data_gnt_o = grant;

    assign addr_ext   = ADDR_W'({data_addr_i[31:2], 2'b00});

    // Payload is zeroed while A is idle so nothing stale leaks onto the bus.
    always_comb begin
        a_opcode_o  = 3'd0;
        a_mask_o    = 4'h0;
        a_data_o    = 32'h0;
        a_address_o = '0;
        if (a_valid_o) begin
            a_address_o = addr_ext;
            if (data_we_i) begin
                a_opcode_o = (data_be_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                a_mask_o   = data_be_i;
                a_data_o   = data_wdata_i;
            end else begin
                a_opcode_o = OP_GET;
                a_mask_o   = 4'hF;
            end
        end
    end

    assign a_param_o  = 3'd0;
    assign a_size_o   = 2'd2;
    assign a_source_o = tail_q;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    // Every issued request already owns a slot, so D never needs to stall.
    assign d_ready_o = drdy_q;
    assign d_fire    = d_valid_i && drdy_q;
    assign slot_ok   = pend_q[d_source_i] && !done_q[d_source_i];
    assign op_ok     = we_q[d_source_i] ? (d_opcode_i == OP_ACCESS_ACK)
                                        : (d_opcode_i == OP_ACCESS_ACK_D);
    assign d_accept  = d_fire && slot_ok && op_ok;
    assign d_bad     = d_fire && !(slot_ok && op_ok);

    // Release is driven only from registered state, so a D beat for the
    // head slot shows up on rvalid one cycle later.
    assign release_head  = pend_q[head_q] && done_q[head_q];
    assign data_rvalid_o = release_head;
    assign data_rdata_o  = release_head ? rdata_q[head_q] : 32'h0;
    assign data_err_o    = release_head ? err_q[head_q]   : 1'b0;

    assign outstanding_o  = count_q;
    assign protocol_err_o = perr_q;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    // The three updates never touch the same slot in one cycle: an accepted
    // D beat targets a pending, not-done slot (never the releasing head and
    // never the free tail), and grant/release share a slot only when the
    // buffer is empty (no release) or full (no grant).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pend_d  = pend_q;
        done_d  = done_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        perr_d  = perr_q || d_bad;

        if (d_accept) begin
            done_d[d_source_i]  = 1'b1;
            err_d[d_source_i]   = d_denied_i || d_corrupt_i;
            rdata_d[d_source_i] = we_q[d_source_i] ? 32'h0 : d_data_i;
        end

        if (grant) begin
            pend_d[tail_q]  = 1'b1;
            done_d[tail_q]  = 1'b0;
            we_d[tail_q]    = data_we_i;
            err_d[tail_q]   = 1'b0;
            rdata_d[tail_q] = 32'h0;
            tail_d          = tail_q + SOURCE_W'(1);
        end

        if (release_head) begin
            pend_d[head_q]  = 1'b0;
            done_d[head_q]  = 1'b0;
            we_d[head_q]    = 1'b0;
            err_d[head_q]   = 1'b0;
            rdata_d[head_q] = 32'h0;
            head_d          = head_q + SOURCE_W'(1);
        end

        case ({grant, release_head})
            2'b10:   count_d = count_q + (SOURCE_W + 1)'(1);
            2'b01:   count_d = count_q - (SOURCE_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            done_q  <= '0;
            we_q    <= '0;
            err_q   <= '0;
            perr_q  <= 1'b0;
            drdy_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                rdata_q[i] <= 32'h0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
            drdy_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ibex_tl_data_adapter.sv
module tb_ibex_tl_data_adapter;

    localparam int SW = 1;
    localparam int N  = 1 << SW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
    logic          data_err_o;
    logic          a_valid_o, a_ready_i;
    logic [2:0]    a_opcode_o, a_param_o;
    logic [1:0]    a_size_o;
    logic [SW-1:0] a_source_o;
    logic [31:0]   a_address_o;
    logic [3:0]    a_mask_o;
    logic [31:0]   a_data_o;
    logic          d_valid_i, d_ready_o;
    logic [2:0]    d_opcode_i;
    logic [SW-1:0] d_source_i;
    logic [31:0]   d_data_i;
    logic          d_denied_i, d_corrupt_i;
    logic [SW:0]   outstanding_o;
    logic          protocol_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    ibex_tl_data_adapter #(.SOURCE_W(SW), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
        .a_param_o(a_param_o), .a_size_o(a_size_o), .a_source_o(a_source_o),
        .a_address_o(a_address_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
        .d_source_i(d_source_i), .d_data_i(d_data_i), .d_denied_i(d_denied_i),
        .d_corrupt_i(d_corrupt_i), .outstanding_o(outstanding_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        a_ready_i = 1; d_valid_i = 0; d_opcode_i = 0; d_source_i = 0; d_data_i = 0;
        d_denied_i = 0; d_corrupt_i = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 0;
        #3;
        rst_ni = 1;
        step();
    endtask

    task automatic drive_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd);
        data_req_i = 1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wd;
    endtask

    task automatic drive_d(input logic [SW-1:0] src, input logic [2:0] op, input logic [31:0] dat,
                           input logic den, input logic cor);
        d_valid_i = 1; d_source_i = src; d_opcode_i = op; d_data_i = dat;
        d_denied_i = den; d_corrupt_i = cor;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        #1;
        n_checks++; if (a_valid_o !== 1'b0) $display("FAIL rst_a_valid: got %0d want 0", a_valid_o); else n_pass++;
        n_checks++; if (data_gnt_o !== 1'b0) $display("FAIL rst_gnt: got %0d want 0", data_gnt_o); else n_pass++;
        n_checks++; if (data_rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %0d want 0", data_rvalid_o); else n_pass++;
        n_checks++; if (outstanding_o !== '0) $display("FAIL rst_outstanding: got %0d want 0", outstanding_o); else n_pass++;
        n_checks++; if (protocol_err_o !== 1'b0) $display("FAIL rst_perr: got %0d want 0", protocol_err_o); else n_pass++;
        #2;
        rst_ni = 1;
        step();
        n_checks++; if (d_ready_o !== 1'b1) $display("FAIL rst_d_ready: got %0d want 1", d_ready_o); else n_pass++;
    endtask

    task automatic test_read();
        apply_reset();
        drive_req(1'b0, 4'h3, 32'h8000_0006, 32'h0);
        #1;
        n_checks++; if (data_gnt_o !== 1'b1) $display("FAIL rd_gnt: got %0d want 1", data_gnt_o); else n_pass++;
        n_checks++; if (a_opcode_o !== 3'd4) $display("FAIL rd_opcode: got %0d want 4", a_opcode_o); else n_pass++;
        n_checks++; if (a_address_o !== 32'h8000_0004) $display("FAIL rd_addr: got %h want 80000004", a_address_o); else n_pass++;
        n_checks++; if (a_mask_o !== 4'hF) $display("FAIL rd_mask: got %h want f", a_mask_o); else n_pass++;
        n_checks++; if (a_source_o !== '0) $display("FAIL rd_source: got %0d want 0", a_source_o); else n_pass++;
        n_checks++; if (a_size_o !== 2'd2 || a_param_o !== 3'd0) $display("FAIL rd_size_param: got %0d/%0d want 2/0", a_size_o, a_param_o); else n_pass++;
        step();
        data_req_i = 0;
        drive_d('0, 3'd1, 32'hDEAD_BEEF, 0, 0);
        #1;
        n_checks++; if (outstanding_o !== 2'd1) $display("FAIL rd_outst: got %0d want 1", outstanding_o); else n_pass++;
        n_checks++; if (data_rvalid_o !== 1'b0) $display("FAIL rd_rvalid_early: got %0d want 0", data_rvalid_o); else n_pass++;
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1) $display("FAIL rd_rvalid: got %0d want 1", data_rvalid_o); else n_pass++;
        n_checks++; if (data_rdata_o !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h want deadbeef", data_rdata_o); else n_pass++;
        n_checks++; if (data_err_o !== 1'b0) $display("FAIL rd_err: got %0d want 0", data_err_o); else n_pass++;
        step();
        n_checks++; if (data_rvalid_o !== 1'b0 || outstanding_o !== '0) $display("FAIL rd_drain: got rvalid %0d outst %0d want 0/0", data_rvalid_o, outstanding_o); else n_pass++;
    endtask

    task automatic test_writes();
        logic [31:0] wd;
        apply_reset();
        wd = $urandom;
        drive_req(1'b1, 4'hF, 32'h0000_1000, wd);
        #1;
        n_checks++; if (a_opcode_o !== 3'd0 || a_mask_o !== 4'hF || a_source_o !== 1'd0) $display("FAIL wr1_a: got op %0d mask %h src %0d want 0/f/0", a_opcode_o, a_mask_o, a_source_o); else n_pass++;
        n_checks++; if (a_data_o !== wd) $display("FAIL wr1_data: got %h want %h", a_data_o, wd); else n_pass++;
        step();
        wd = $urandom;
        drive_req(1'b1, 4'h3, 32'h0000_1004, wd);
        #1;
        n_checks++; if (data_gnt_o !== 1'b1 || a_opcode_o !== 3'd1 || a_mask_o !== 4'h3 || a_source_o !== 1'd1) $display("FAIL wr2_a: got gnt %0d op %0d mask %h src %0d want 1/1/3/1", data_gnt_o, a_opcode_o, a_mask_o, a_source_o); else n_pass++;
        step();
        data_req_i = 0;
        drive_d(1'd0, 3'd0, 32'h1234_5678, 0, 0);
        step();
        drive_d(1'd1, 3'd0, 32'h9ABC_DEF0, 0, 0);
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0) $display("FAIL wr_rsp1: got rvalid %0d rdata %h want 1/0", data_rvalid_o, data_rdata_o); else n_pass++;
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0) $display("FAIL wr_rsp2: got rvalid %0d rdata %h want 1/0", data_rvalid_o, data_rdata_o); else n_pass++;
        step();
        n_checks++; if (data_rvalid_o !== 1'b0 || outstanding_o !== '0 || protocol_err_o !== 1'b0) $display("FAIL wr_drain: got rvalid %0d outst %0d perr %0d want 0/0/0", data_rvalid_o, outstanding_o, protocol_err_o); else n_pass++;
    endtask

    task automatic test_out_of_order();
        apply_reset();
        drive_req(1'b0, 4'hF, 32'h100, 0);
        step();
        drive_req(1'b0, 4'hF, 32'h104, 0);
        step();
        data_req_i = 0;
        drive_d(1'd1, 3'd1, 32'h22, 0, 0);
        step();
        drive_d(1'd0, 3'd1, 32'h11, 0, 0);
        #1;
        n_checks++; if (data_rvalid_o !== 1'b0) $display("FAIL ooo_hold: got rvalid %0d want 0", data_rvalid_o); else n_pass++;
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h11) $display("FAIL ooo_first: got rvalid %0d rdata %h want 1/11", data_rvalid_o, data_rdata_o); else n_pass++;
        step();
        n_checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h22) $display("FAIL ooo_second: got rvalid %0d rdata %h want 1/22", data_rvalid_o, data_rdata_o); else n_pass++;
        step();
        n_checks++; if (data_rvalid_o !== 1'b0 || protocol_err_o !== 1'b0) $display("FAIL ooo_end: got rvalid %0d perr %0d want 0/0", data_rvalid_o, protocol_err_o); else n_pass++;
    endtask

    task automatic test_full_stall();
        apply_reset();
        drive_req(1'b0, 4'hF, 32'h200, 0);
        step();
        step();
        #1;
        n_checks++; if (a_valid_o !== 1'b0 || data_gnt_o !== 1'b0 || outstanding_o !== 2'd2) $display("FAIL full_hold: got valid %0d gnt %0d outst %0d want 0/0/2", a_valid_o, data_gnt_o, outstanding_o); else n_pass++;
        drive_d(1'd0, 3'd1, 32'hAAAA_0000, 0, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_gnt_o !== 1'b0) $display("FAIL full_release: got rvalid %0d gnt %0d want 1/0", data_rvalid_o, data_gnt_o); else n_pass++;
        step();
        n_checks++; if (data_gnt_o !== 1'b1 || a_source_o !== 1'd0 || outstanding_o !== 2'd1) $display("FAIL full_regrant: got gnt %0d src %0d outst %0d want 1/0/1", data_gnt_o, a_source_o, outstanding_o); else n_pass++;
        step();
        data_req_i = 0;
        #1;
        n_checks++; if (outstanding_o !== 2'd2) $display("FAIL full_refill: got outst %0d want 2", outstanding_o); else n_pass++;
    endtask

    task automatic test_errors();
        apply_reset();
        drive_req(1'b0, 4'hF, 32'h300, 0);
        step();
        data_req_i = 0;
        drive_d(1'd0, 3'd1, 32'h0, 1, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) $display("FAIL err_denied: got rvalid %0d err %0d rdata %h want 1/1/0", data_rvalid_o, data_err_o, data_rdata_o); else n_pass++;
        step();
        drive_req(1'b1, 4'h1, 32'h304, 32'h55);
        step();
        data_req_i = 0;
        drive_d(1'd1, 3'd0, 32'h0, 0, 1);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || protocol_err_o !== 1'b0) $display("FAIL err_corrupt: got rvalid %0d err %0d perr %0d want 1/1/0", data_rvalid_o, data_err_o, protocol_err_o); else n_pass++;
        step();
        // read answered with AccessAck: dropped, flagged
        drive_req(1'b0, 4'hF, 32'h308, 0);
        step();
        data_req_i = 0;
        drive_d(1'd0, 3'd0, 32'h77, 0, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (protocol_err_o !== 1'b1 || data_rvalid_o !== 1'b0 || outstanding_o !== 2'd1) $display("FAIL err_opcode: got perr %0d rvalid %0d outst %0d want 1/0/1", protocol_err_o, data_rvalid_o, outstanding_o); else n_pass++;
        // unexpected source
        drive_d(1'd1, 3'd1, 32'h99, 0, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (protocol_err_o !== 1'b1 || outstanding_o !== 2'd1 || data_rvalid_o !== 1'b0) $display("FAIL err_nonpend: got perr %0d outst %0d rvalid %0d want 1/1/0", protocol_err_o, outstanding_o, data_rvalid_o); else n_pass++;
        drive_d(1'd0, 3'd1, 32'h1357, 0, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h1357 || protocol_err_o !== 1'b1) $display("FAIL err_sticky: got rvalid %0d rdata %h perr %0d want 1/1357/1", data_rvalid_o, data_rdata_o, protocol_err_o); else n_pass++;
        step();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        drive_req(1'b0, 4'hF, 32'h400, 0);
        step();
        data_req_i = 0;
        #2;
        rst_ni = 0;
        #1;
        n_checks++; if (outstanding_o !== '0 || data_rvalid_o !== 1'b0 || a_valid_o !== 1'b0 || protocol_err_o !== 1'b0) $display("FAIL midrst_out: got outst %0d rvalid %0d valid %0d perr %0d want 0", outstanding_o, data_rvalid_o, a_valid_o, protocol_err_o); else n_pass++;
        #1;
        rst_ni = 1;
        step();
        n_checks++; if (d_ready_o !== 1'b1 || outstanding_o !== '0) $display("FAIL midrst_after: got d_ready %0d outst %0d want 1/0", d_ready_o, outstanding_o); else n_pass++;
        drive_d(1'd0, 3'd1, 32'h1, 0, 0);
        step();
        d_valid_i = 0;
        #1;
        n_checks++; if (protocol_err_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL midrst_stale: got perr %0d rvalid %0d want 1/0", protocol_err_o, data_rvalid_o); else n_pass++;
    endtask

    typedef struct {
        logic [SW-1:0] src;
        bit            we;
        bit            done;
        logic [31:0]   data;
        bit            err;
    } txn_t;

    task automatic test_random();
        txn_t        q[$];
        int          next_tag;
        int          open_idx[$];
        int          pick;
        bit          exp_gnt, exp_rv;
        logic [2:0]  exp_op;
        logic [3:0]  exp_mask;
        logic [31:0] exp_rd;
        bit          exp_err;
        txn_t        t;
        apply_reset();
        next_tag = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle_inputs();
            a_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                drive_req($urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
            open_idx.delete();
            for (int i = 0; i < q.size(); i++)
                if (!q[i].done) open_idx.push_back(i);
            pick = -1;
            if (open_idx.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick = open_idx[$urandom_range(0, open_idx.size() - 1)];
                drive_d(q[pick].src, q[pick].we ? 3'd0 : 3'd1, $urandom,
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
            #1;
            exp_gnt = data_req_i && a_ready_i && (q.size() < N);
            exp_rv  = (q.size() > 0) && q[0].done;
            exp_rd  = exp_rv ? q[0].data : 32'h0;
            exp_err = exp_rv ? q[0].err : 1'b0;
            n_checks++; if (data_gnt_o !== exp_gnt) $display("FAIL rnd_gnt c%0d: got %0d want %0d", cyc, data_gnt_o, exp_gnt); else n_pass++;
            n_checks++; if (data_rvalid_o !== exp_rv || data_rdata_o !== exp_rd || data_err_o !== exp_err) $display("FAIL rnd_rsp c%0d: got %0d/%h/%0d want %0d/%h/%0d", cyc, data_rvalid_o, data_rdata_o, data_err_o, exp_rv, exp_rd, exp_err); else n_pass++;
            n_checks++; if (outstanding_o !== (SW + 1)'(q.size()) || protocol_err_o !== 1'b0) $display("FAIL rnd_state c%0d: got outst %0d perr %0d want %0d/0", cyc, outstanding_o, protocol_err_o, q.size()); else n_pass++;
            if (exp_gnt) begin
                exp_op   = !data_we_i ? 3'd4 : (data_be_i == 4'hF ? 3'd0 : 3'd1);
                exp_mask = data_we_i ? data_be_i : 4'hF;
                n_checks++; if (a_opcode_o !== exp_op || a_mask_o !== exp_mask || a_address_o !== (data_addr_i & 32'hFFFF_FFFC) || a_source_o !== SW'(next_tag)) $display("FAIL rnd_a c%0d: got op %0d mask %h addr %h src %0d want %0d/%h/%h/%0d", cyc, a_opcode_o, a_mask_o, a_address_o, a_source_o, exp_op, exp_mask, data_addr_i & 32'hFFFF_FFFC, next_tag); else n_pass++;
            end
            step();
            if (pick >= 0) begin
                q[pick].done = 1;
                q[pick].err  = d_denied_i || d_corrupt_i;
                q[pick].data = q[pick].we ? 32'h0 : d_data_i;
            end
            if (exp_rv) void'(q.pop_front());
            if (exp_gnt) begin
                t.src = SW'(next_tag); t.we = data_we_i; t.done = 0; t.data = 0; t.err = 0;
                q.push_back(t);
                next_tag = (next_tag + 1) % N;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1;
        #2;
        test_reset();
        test_read();
        test_writes();
        test_out_of_order();
        test_full_stall();
        test_errors();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_tl_data_adapter.md
Name: ibex_tl_data_adapter

Overview:
- Bridges the Ibex core data memory interface (req/gnt/rvalid) onto a TileLink-UL client port (channels A/D).
- Sits directly downstream of the core wrapper's data_* ports and feeds the tile's TileLink crossbar.
- Allows up to 2**SOURCE_W transactions in flight, each tagged by a distinct a_source.
- Accepts out-of-order D responses and returns them to the core strictly in issue order.

Parameters:
- SOURCE_W, 1: width of a_source/d_source. Outstanding capacity is N = 2**SOURCE_W. Legal range 1..3.
- ADDR_W, 32: TileLink address width. ADDR_W must be >= 32; upper bits are zero-extended.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core request
- data_gnt_o  out  1  request accepted
- data_rvalid_o  out  1  response valid, one cycle per accepted request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- data_err_o  out  1  bus error, qualified by rvalid
- a_valid_o  out  1  TL A valid
- a_ready_i  in  1  TL A ready
- a_opcode_o  out  3  Get=4, PutFullData=0, PutPartialData=1
- a_param_o  out  3  always 0
- a_size_o  out  2  always 2
- a_source_o  out  SOURCE_W  transaction tag
- a_address_o  out  ADDR_W  word-aligned address
- a_mask_o  out  4  byte mask
- a_data_o  out  32  write data
- d_valid_i  in  1  TL D valid
- d_ready_o  out  1  TL D ready
- d_opcode_i  in  3  AccessAck=0, AccessAckData=1
- d_source_i  in  SOURCE_W  response tag
- d_data_i  in  32  response data
- d_denied_i  in  1  denied
- d_corrupt_i  in  1  corrupt
- outstanding_o  out  SOURCE_W+1  slots in use
- protocol_err_o  out  1  sticky protocol violation

Behaviour:
- Reset values: all outputs 0; d_ready_o = 1; head = tail = count = 0; all slots cleared.
- State: N-entry circular slot buffer with head (oldest), tail (next allocated) and count. Per slot: pend, done, is_write, rdata, err.
- Issue path, combinational:
  - a_valid_o = data_req_i && (count < N); data_gnt_o = a_valid_o && a_ready_i.
  - a_source_o = tail; a_address_o = {zero-ext, data_addr_i[31:2], 2'b00}.
  - Opcode: read -> Get, mask 4'hF. Write with be=4'hF -> PutFullData. Any other be -> PutPartialData. Write mask = be, a_data_o = wdata.
  - be = 0 on a write is still issued as PutPartialData.
- On grant: slot[tail] gets pend=1, done=0, is_write=we; tail++ modulo N.
- Full: when count == N, a_valid_o and data_gnt_o are held 0 while data_req_i waits. The A channel never sees a valid that is withdrawn without a handshake.
- Response path: d_ready_o is always 1 out of reset; a slot is pre-reserved for every request.
- On a D beat with slot[d_source].pend && !done:
  - Set done. err = d_denied_i | d_corrupt_i.
  - rdata = d_data_i for reads, 0 for writes.
- protocol_err_o sets, and the beat is otherwise dropped, if either:
  - the slot is not pending or already done; or
  - the opcode mismatches (a read must get AccessAckData, a write must get AccessAck).
- protocol_err_o stays set until reset.
- Release:
  - data_rvalid_o = slot[head].pend && slot[head].done, driven from registered state only. Earliest rvalid is the cycle after the D beat.
  - data_rdata_o/data_err_o come from slot[head] and are 0 when rvalid = 0.
  - On rvalid, clear slot[head] and head++. At most one release per cycle; no backpressure from the core.
- count = number of pend slots; outstanding_o = count.
  - Same-cycle grant and release leave count unchanged.
  - A slot released in cycle t can be re-granted from cycle t+1.
- Simultaneous D beat to the head slot and release of a different slot cannot occur (release requires head done). A D beat for the head slot becomes visible next cycle.
- Async reset mid-operation discards all slots. Later D beats then hit non-pending slots and set protocol_err_o.
- Bursts (a_size > 2) are never generated.

Test Plan:
- Read: req addr=0x8000_0006, we=0, a_ready=1 -> same-cycle gnt; A opcode=4, address=0x8000_0004, mask=F, source=0. D AccessAckData data=0xDEADBEEF at t -> rvalid at t+1, rdata=0xDEADBEEF, err=0.
- Writes: be=F then be=3, back-to-back -> opcodes 0 then 1, masks F/3, sources 0/1. AccessAcks give two rvalid pulses with rdata=0.
- Out-of-order, SOURCE_W=1: two reads issued; D for source 1 (0x22) arrives before source 0 (0x11) -> rvalids are 0x11 then 0x22, in order; no protocol_err.
- Full/stall: two reads outstanding, third req held, a_ready=1 -> a_valid=0, gnt=0, outstanding_o=2. After the first release, gnt the next cycle with source 0.
- Errors:
  - d_denied=1 on a read -> rvalid with err=1, rdata=0.
  - D beat for a non-pending source -> protocol_err_o=1 sticky; outstanding_o unchanged.
- Reset: assert rst_ni low with one read outstanding -> all outputs 0 immediately, outstanding_o=0, d_ready_o=1 after release.
